// File: rtl/ln_range_reduce.sv
// Argument reduction for the Ln datapath: normalises x = m * 2^k with m in [1,2)
// by one-bit left shifts, and returns y = m - 1 with the signed exponent k.
module ln_range_reduce #(
    parameter int W    = 16,
    parameter int FRAC = 8,
    parameter int KW   = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [W-1:0]         x,
    output logic                 Ready,
    output logic                 done,
    output logic [W-2:0]         y,
    output logic signed [KW-1:0] k,
    output logic                 err
);

    typedef enum logic [2:0] {IDLE, START, LOAD, SHIFT, DONE} state_t;

    // Exponent when the leading one already sits in the MSB.
    localparam logic signed [KW-1:0] EXP_INIT = KW'(W - 1 - FRAC);

    state_t                 state;
    logic [W-1:0]           norm;
    logic signed [KW-1:0]   exponent;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            norm     <= '0;
            exponent <= '0;
            y        <= '0;
            k        <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                IDLE:  if (start) state <= START;
                START: if (!start) state <= LOAD;
                LOAD: begin
                    norm     <= x;
                    exponent <= EXP_INIT;
                    err      <= 1'b0;
                    if (x == '0) begin
                        err   <= 1'b1;
                        y     <= '0;
                        k     <= '0;
                        state <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Results are captured on the transition so they are valid during DONE.
                    if (norm[W-1]) begin
                        y     <= norm[W-2:0];
                        k     <= exponent;
                        state <= DONE;
                    end else begin
                        norm     <= {norm[W-2:0], 1'b0};
                        exponent <= exponent - KW'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign Ready = (state == IDLE);
    assign done  = (state == DONE);

endmodule

// File: doc/ln_range_reduce.md
Name: ln_range_reduce

Overview:
- Upstream argument-reduction stage for the Ln series datapath and controller.
- Takes an unsigned fixed-point operand x and normalises it by sequential one-bit left shifts so that x = m * 2^k with m in [1,2).
- Outputs the series argument y = m - 1 as a pure fraction, plus the signed exponent k. The downstream ln(1+y) unit computes its result and a later adder adds k*ln2.
- Uses the same start/Ready handshake as the Ln controller. The done pulse drives that controller's start input directly.

Parameters:
- W, 16, input width; x is unsigned Q(W-FRAC).FRAC.
- FRAC, 8, number of fractional bits of x.
- KW, 6, width of the signed exponent output k (two's complement); must hold the range -FRAC to W-1-FRAC.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low. Forces state and all outputs to their reset values while low.
- start  input  1  request. Accepted as a high level followed by a low level, identical to the Ln controller protocol.
- x  input  W  operand, unsigned Q(W-FRAC).FRAC. Sampled in LOAD only.
- Ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse when y, k and err are valid.
- y  output  W-1  m - 1 as unsigned Q0.(W-1); equals the normalised register bits [W-2:0].
- k  output  KW  signed exponent.
- err  output  1  set when x == 0, i.e. ln is undefined.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - Internal register norm = 0, internal exponent = 0.
  - y = 0, k = 0, err = 0, done = 0; Ready = 1 because the state is IDLE.
- States: IDLE, START, LOAD, SHIFT, DONE. Outputs are decoded from state, except y, k and err, which are registers.
- IDLE:
  - Ready = 1.
  - start = 1 -> START; otherwise stay.
- START:
  - Stay while start = 1.
  - start = 0 -> LOAD.
- LOAD:
  - norm <= x; exponent <= W-1-FRAC; err <= 0.
  - If x == 0: err <= 1, y <= 0, k <= 0, go to DONE.
  - Otherwise go to SHIFT.
- SHIFT:
  - If norm[W-1] == 1, go to DONE with no shift.
  - Otherwise norm <= norm << 1 (zero fill) and exponent <= exponent - 1; stay in SHIFT.
  - Only one check or shift happens per cycle.
- DONE:
  - done = 1 for exactly one cycle.
  - y <= norm[W-2:0] and k <= exponent are captured on entry to DONE, so they are valid in the done cycle.
  - The zero case keeps err = 1, y = 0, k = 0.
  - Next state is IDLE.
- Output hold: y, k and err hold their values until the next LOAD clears err or a new result is captured.
- Latency: with p = index of the leading one of x, measured from the first cycle start is sampled low in START:
  - 1 cycle to LOAD;
  - then (W-1-p)+1 cycles in SHIFT;
  - then 1 cycle in DONE.
  - For x == 0, DONE follows LOAD directly.
- start is ignored in LOAD, SHIFT and DONE. A start still high when IDLE returns begins a new request.
- No overflow is possible: exponent is bounded between -FRAC and W-1-FRAC, and the shift count never exceeds W-1.
- Reset in any state aborts the operation immediately. No done pulse is generated and outputs clear.
- Ready and done are never high in the same cycle.

Test Plan:
- x=0x0100 (1.0): pulse start 2 cycles -> 7 shifts, 8 SHIFT cycles; done with y=0x0000, k=0, err=0. Ready stays low from START through DONE.
- x=0x0300 (3.0) -> done with y=0x4000 (0.5), k=1 after 7 SHIFT cycles. x=0x8000 (128.0) -> y=0, k=7, 1 SHIFT cycle.
- x=0x0001 (2^-8) -> 15 shifts, y=0, k=-8 (6'b111000). x=0x00C0 (0.75) -> y=0x4000, k=-1.
- x=0: done one cycle after LOAD, err=1, y=0, k=0. A following x=0x0200 request clears err and gives k=1, y=0.
- Hold start high for 5 cycles -> state stays START with no LOAD until start falls. Toggle start during SHIFT -> no effect on the result.
- Assert rst low mid-SHIFT on x=0x0001 -> Ready=1, y=0, k=0, done never pulses. After release, a new request completes normally.
